// File: rtl/irq_pkg.sv
// Shared sizes, FSM encodings and helpers for the interrupt request controller.
package irq_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  // One-hot mask for a request index.
  function automatic logic [N-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// 8-to-3 priority encoder, bit 7 has the highest priority.
module prio_enc8
  import irq_pkg::*;
(
  input  logic [N-1:0]     cand_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (cand_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign any_o = |cand_i;

endmodule

// File: rtl/irq_req_ctrl.sv
// Request capture, sticky pending/overflow tracking and valid/ready grant stage.
module irq_req_ctrl
  import irq_pkg::*;
#(
  parameter bit EDGE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask,
  input  logic             ovf_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     pending,
  output logic [N-1:0]     overflow
);

  logic [N-1:0]     req_q;
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     overflow_q, overflow_d;
  logic [0:0]       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;

  logic [N-1:0]     set;
  logic [N-1:0]     clr;
  logic [N-1:0]     cand;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             handshake;

  assign handshake = out_valid_q & out_ready;
  assign cand      = pending_q & ~mask;

  prio_enc8 u_prio_enc8 (
    .cand_i (cand),
    .idx_o  (enc_idx),
    .any_o  (enc_any)
  );

  // Capture new requests and fold them into pending; set beats a same-cycle clear.
  always_comb begin
    set        = EDGE ? (req_in & ~req_q) : req_in;
    clr        = handshake ? idx_onehot(out_idx_q) : '0;
    pending_d  = (pending_q & ~clr) | set;
    overflow_d = overflow_q;
    if (EDGE) overflow_d = overflow_q | (set & pending_q & ~clr);
    if (ovf_clr) overflow_d = '0;
  end

  // Grant FSM: pick the top candidate in IDLE, hold the offer until accepted.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    case (state_q)
      ST_IDLE: begin
        out_valid_d = 1'b0;
        if (enc_any) begin
          out_idx_d   = enc_idx;
          out_valid_d = 1'b1;
          state_d     = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  // State, capture and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= '0;
      pending_q   <= '0;
      overflow_q  <= '0;
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      req_q       <= req_in;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_irq_req_ctrl.sv
// Scenario bench for irq_req_ctrl: edge-capture instance plus a level-capture instance.
module tb_irq_req_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_in, mask;
  logic       ovf_clr, out_ready, out_valid;
  logic [2:0] out_idx;
  logic [7:0] pending, overflow;

  logic [7:0] req_l, mask_l;
  logic       ovf_clr_l, ready_l, valid_l;
  logic [2:0] idx_l;
  logic [7:0] pending_l, overflow_l;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  irq_req_ctrl #(.EDGE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask), .ovf_clr(ovf_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .pending(pending), .overflow(overflow)
  );

  irq_req_ctrl #(.EDGE(1'b0)) dut_lvl (
    .clk(clk), .rst_n(rst_n), .req_in(req_l), .mask(mask_l), .ovf_clr(ovf_clr_l),
    .out_valid(valid_l), .out_ready(ready_l), .out_idx(idx_l),
    .pending(pending_l), .overflow(overflow_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance past the next rising edge; outputs are stable when this returns.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for an offer, return its index, then accept it. No checking here.
  task automatic drain_one(output int idx, output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) begin
        timeout = 1'b0;
        break;
      end
      cyc();
    end
    idx = int'(out_idx);
    if (!timeout) begin
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    total++;
    if (out_valid !== 1'b0 || out_idx !== 3'd0 || pending !== 8'h00 || overflow !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: valid=%b idx=%0d pend=%h ovf=%h want 0/0/00/00",
               out_valid, out_idx, pending, overflow);
    end
    total++;
    if (valid_l !== 1'b0 || pending_l !== 8'h00) begin
      bad++;
      $display("FAIL reset_state_lvl: valid=%b pend=%h want 0/00", valid_l, pending_l);
    end
  endtask

  task automatic test_single();
    int got;
    out_ready = 1'b1;
    req_in = 8'h04;
    exp_q.push_back(2);
    cyc();
    req_in = 8'h00;
    total++;
    if (pending !== 8'h04 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_capture: pend=%h valid=%b want 04/0", pending, out_valid);
    end
    cyc();
    got = exp_q.pop_front();
    total++;
    if (out_valid !== 1'b1 || int'(out_idx) !== got) begin
      bad++;
      $display("FAIL single_offer: valid=%b idx=%0d want 1/%0d", out_valid, out_idx, got);
    end
    cyc();
    total++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      bad++;
      $display("FAIL single_clear: valid=%b pend=%h want 0/00", out_valid, pending);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_priority();
    int got, want;
    bit to;
    req_in = 8'h12;
    exp_q.push_back(4);
    exp_q.push_back(7);
    exp_q.push_back(1);
    cyc();
    req_in = 8'h00;
    cyc();
    total++;
    if (out_valid !== 1'b1 || out_idx !== 3'd4) begin
      bad++;
      $display("FAIL prio_first: valid=%b idx=%0d want 1/4", out_valid, out_idx);
    end
    req_in = 8'h80;
    cyc();
    req_in = 8'h00;
    cyc();
    total++;
    if (out_valid !== 1'b1 || out_idx !== 3'd4 || pending !== 8'h92) begin
      bad++;
      $display("FAIL prio_stable: valid=%b idx=%0d pend=%h want 1/4/92", out_valid, out_idx, pending);
    end
    for (int k = 0; k < 3; k++) begin
      drain_one(got, to);
      want = exp_q.pop_front();
      total++;
      if (to || got !== want) begin
        bad++;
        $display("FAIL prio_order%0d: idx=%0d timeout=%b want %0d", k, got, to, want);
      end
    end
    total++;
    if (pending !== 8'h00) begin
      bad++;
      $display("FAIL prio_empty: pend=%h want 00", pending);
    end
  endtask

  task automatic test_mask();
    int got, want;
    bit to, seen;
    mask = 8'h80;
    req_in = 8'h81;
    exp_q.push_back(0);
    exp_q.push_back(7);
    cyc();
    req_in = 8'h00;
    drain_one(got, to);
    want = exp_q.pop_front();
    total++;
    if (to || got !== want) begin
      bad++;
      $display("FAIL mask_low: idx=%0d timeout=%b want %0d", got, to, want);
    end
    mask = 8'h00;
    drain_one(got, to);
    want = exp_q.pop_front();
    total++;
    if (to || got !== want) begin
      bad++;
      $display("FAIL mask_release: idx=%0d timeout=%b want %0d", got, to, want);
    end
    mask = 8'hFF;
    req_in = 8'h08;
    cyc();
    req_in = 8'h00;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen || pending !== 8'h08) begin
      bad++;
      $display("FAIL mask_all: valid_seen=%b pend=%h want 0/08", seen, pending);
    end
    mask = 8'h00;
    exp_q.push_back(3);
    drain_one(got, to);
    want = exp_q.pop_front();
    total++;
    if (to || got !== want) begin
      bad++;
      $display("FAIL mask_unmask: idx=%0d timeout=%b want %0d", got, to, want);
    end
  endtask

  task automatic test_overflow();
    int got, want;
    bit to;
    req_in = 8'h08;
    cyc();
    req_in = 8'h00;
    cyc();
    req_in = 8'h08;
    cyc();
    req_in = 8'h00;
    total++;
    if (overflow !== 8'h08) begin
      bad++;
      $display("FAIL ovf_set: ovf=%h want 08", overflow);
    end
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    total++;
    if (overflow !== 8'h00) begin
      bad++;
      $display("FAIL ovf_clr: ovf=%h want 00", overflow);
    end
    req_in = 8'h08;
    ovf_clr = 1'b1;
    cyc();
    req_in = 8'h00;
    ovf_clr = 1'b0;
    total++;
    if (overflow !== 8'h00 || pending !== 8'h08) begin
      bad++;
      $display("FAIL ovf_clr_prio: ovf=%h pend=%h want 00/08", overflow, pending);
    end
    exp_q.push_back(3);
    drain_one(got, to);
    want = exp_q.pop_front();
    total++;
    if (to || got !== want || pending !== 8'h00) begin
      bad++;
      $display("FAIL ovf_drain: idx=%0d timeout=%b pend=%h want %0d/00", got, to, pending, want);
    end
  endtask

  task automatic test_collision();
    int got, want;
    bit to;
    req_in = 8'h20;
    exp_q.push_back(5);
    exp_q.push_back(5);
    cyc();
    req_in = 8'h00;
    cyc();
    want = exp_q.pop_front();
    total++;
    if (out_valid !== 1'b1 || int'(out_idx) !== want) begin
      bad++;
      $display("FAIL coll_offer: valid=%b idx=%0d want 1/%0d", out_valid, out_idx, want);
    end
    out_ready = 1'b1;
    req_in = 8'h20;
    cyc();
    out_ready = 1'b0;
    req_in = 8'h00;
    total++;
    if (pending !== 8'h20 || out_valid !== 1'b0 || overflow !== 8'h00) begin
      bad++;
      $display("FAIL coll_handshake: pend=%h valid=%b ovf=%h want 20/0/00", pending, out_valid, overflow);
    end
    drain_one(got, to);
    want = exp_q.pop_front();
    total++;
    if (to || got !== want || pending !== 8'h00) begin
      bad++;
      $display("FAIL coll_regrant: idx=%0d timeout=%b pend=%h want %0d/00", got, to, pending, want);
    end
  endtask

  task automatic test_level();
    int want;
    bit exp_v;
    ready_l = 1'b1;
    req_l = 8'h10;
    cyc();
    total++;
    if (valid_l !== 1'b0 || pending_l !== 8'h10) begin
      bad++;
      $display("FAIL lvl_capture: valid=%b pend=%h want 0/10", valid_l, pending_l);
    end
    for (int i = 0; i < 7; i++) begin
      exp_v = (i % 2 == 0);
      if (exp_v) exp_q.push_back(4);
      cyc();
      total++;
      if (valid_l !== exp_v || overflow_l !== 8'h00 || pending_l !== 8'h10) begin
        bad++;
        $display("FAIL lvl_cycle%0d: valid=%b ovf=%h pend=%h want %b/00/10",
                 i, valid_l, overflow_l, pending_l, exp_v);
      end else if (exp_v) begin
        want = exp_q.pop_front();
        total++;
        if (int'(idx_l) !== want) begin
          bad++;
          $display("FAIL lvl_idx%0d: idx=%0d want %0d", i, idx_l, want);
        end
      end
    end
    req_l = 8'h00;
    cyc();
    ready_l = 1'b0;
    total++;
    if (valid_l !== 1'b0 || pending_l !== 8'h00) begin
      bad++;
      $display("FAIL lvl_release: valid=%b pend=%h want 0/00", valid_l, pending_l);
    end
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    int got, want;
    bit to;
    req_in = 8'h01;
    cyc();
    req_in = 8'h00;
    cyc();
    req_in = 8'h01;
    cyc();
    req_in = 8'h00;
    total++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0 || overflow !== 8'h01) begin
      bad++;
      $display("FAIL arst_setup: valid=%b idx=%0d ovf=%h want 1/0/01", out_valid, out_idx, overflow);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || pending !== 8'h00 || overflow !== 8'h00) begin
      bad++;
      $display("FAIL arst_midoffer: valid=%b pend=%h ovf=%h want 0/00/00", out_valid, pending, overflow);
    end
    req_in = 8'h40;
    cyc();
    rst_n = 1'b1;
    cyc();
    req_in = 8'h00;
    total++;
    if (pending !== 8'h40) begin
      bad++;
      $display("FAIL arst_release_edge: pend=%h want 40", pending);
    end
    exp_q.push_back(6);
    drain_one(got, to);
    want = exp_q.pop_front();
    total++;
    if (to || got !== want) begin
      bad++;
      $display("FAIL arst_grant: idx=%0d timeout=%b want %0d", got, to, want);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_in = '0; mask = '0; ovf_clr = 1'b0; out_ready = 1'b0;
    req_l = '0; mask_l = '0; ovf_clr_l = 1'b0; ready_l = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_overflow();
    test_collision();
    test_level();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
